pe_enable_stack: RTL and testbench

PE_ENABLE_STACK -- requirements
Module: pe_enable_stack

---
 rtl/pe_enable_stack.sv | 176 +++++++++++++++++
 tb/tb_pe_enable_stack.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pe_enable_stack.sv
// Per-PE enable stack for SIMD control flow.
// Every PE keeps a stack of enable bits. All PEs share one depth pointer, so
// a push or pop moves every lane's stack at once. The top-of-stack bit of each
// lane is the PE's enable. Overflow and underflow attempts leave all state
// untouched and raise sticky error flags.

// One PE's stack. The top level is the word at index 'depth'. The enable
// output register always mirrors that word, so the top can be read from a flop
// and not through a depth-indexed mux.
module pe_enable_lane #(
  parameter int DEPTH = 32,
  parameter int CW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] depth,
  input  logic          do_push,
  input  logic          do_pop,
  input  logic          do_all,
  input  logic          do_else,
  input  logic          cond,
  output logic          en,
  output logic          en_nxt
);

  logic [DEPTH-1:0] stk;
  logic             below;
  logic             wr;
  logic [CW-1:0]    widx;

  // Level directly under the top. At depth 0 there is no such level, and the
  // callers never use it in that case.
  always_comb begin
    below = 1'b0;
    for (int k = 1; k < DEPTH; k++)
      if (depth == CW'(k)) below = stk[k-1];
  end

  // Value the top of the stack takes after this cycle's operation.
  always_comb begin
    en_nxt = en;
    if (do_push)      en_nxt = en & cond;
    else if (do_pop)  en_nxt = below;
    else if (do_all)  en_nxt = 1'b1;
    else if (do_else) en_nxt = below & ~en;
  end

  // A push writes the new level above the old top. ALLEN and ELSEN rewrite
  // the top in place. A pop writes nothing, because stale upper levels are
  // never read again before they are rewritten.
  assign wr   = do_push | do_all | do_else;
  assign widx = do_push ? depth + CW'(1) : depth;

  // Stack storage and the registered top copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      stk <= DEPTH'(1);
      en  <= 1'b1;
    end else begin
      en <= en_nxt;
      for (int k = 0; k < DEPTH; k++)
        if (wr && widx == CW'(k)) stk[k] <= en_nxt;
    end
  end

endmodule

// Top level: decodes the operation, applies the overflow and underflow guards,
// owns the shared depth pointer and the error flags, and fans the qualified
// operation out to one lane per PE.
module pe_enable_stack #(
  parameter int NPROC = 4,
  parameter int DEPTH = 32,
  parameter int CW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       op,
  input  logic             op_valid,
  input  logic             squash,
  input  logic [NPROC-1:0] cond,
  input  logic             err_clr,
  output logic [NPROC-1:0] en,
  output logic             any_en,
  output logic [CW-1:0]    depth,
  output logic             err_ovf,
  output logic             err_unf
);

  localparam logic [2:0] OP_PUSHEN = 3'b001;
  localparam logic [2:0] OP_POPEN  = 3'b010;
  localparam logic [2:0] OP_ALLEN  = 3'b011;
  localparam logic [2:0] OP_ELSEN  = 3'b100;

  logic             acc;
  logic             at_top;
  logic             at_bot;
  logic             do_push;
  logic             do_pop;
  logic             do_all;
  logic             do_else;
  logic             set_ovf;
  logic             set_unf;
  logic [NPROC-1:0] en_nxt;

  // Decode the operation. An operation that would move the pointer past
  // either end is turned into an error flag and does nothing else.
  always_comb begin
    acc     = op_valid & ~squash;
    at_top  = (depth == CW'(DEPTH-1));
    at_bot  = (depth == '0);
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_all  = 1'b0;
    do_else = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (acc) begin
      unique case (op)
        OP_PUSHEN: begin do_push = ~at_top; set_ovf = at_top; end
        OP_POPEN:  begin do_pop  = ~at_bot; set_unf = at_bot; end
        OP_ALLEN:  do_all = 1'b1;
        OP_ELSEN:  begin do_else = ~at_bot; set_unf = at_bot; end
        default:   ;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NPROC; g++) begin : g_lane
      pe_enable_lane #(
        .DEPTH (DEPTH),
        .CW    (CW)
      ) u_lane (
        .clk     (clk),
        .reset   (reset),
        .depth   (depth),
        .do_push (do_push),
        .do_pop  (do_pop),
        .do_all  (do_all),
        .do_else (do_else),
        .cond    (cond[g]),
        .en      (en[g]),
        .en_nxt  (en_nxt[g])
      );
    end
  endgenerate

  // Shared depth pointer. The guards above keep it from wrapping.
  always_ff @(posedge clk) begin
    if (reset)        depth <= '0;
    else if (do_push) depth <= depth + CW'(1);
    else if (do_pop)  depth <= depth - CW'(1);
  end

  // any_en is built from the next enables, so it matches en in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) any_en <= 1'b1;
    else       any_en <= |en_nxt;
  end

  // Sticky error flags. A set in the same cycle as err_clr takes precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (set_ovf)      err_ovf <= 1'b1;
      else if (err_clr) err_ovf <= 1'b0;
      if (set_unf)      err_unf <= 1'b1;
      else if (err_clr) err_unf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_enable_stack.sv
// Bench for pe_enable_stack (NPROC=4, DEPTH=4). The reference model is a queue
// of enable words whose last entry is the top. A directed sequence with
// literal expectations pins the model, and then randomized traffic follows.
module tb_pe_enable_stack;

  localparam int NPROC = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [2:0]       op = 3'd0;
  logic             op_valid = 1'b0;
  logic             squash = 1'b0;
  logic [NPROC-1:0] cond = '0;
  logic             err_clr = 1'b0;
  logic [NPROC-1:0] en;
  logic             any_en;
  logic [CW-1:0]    depth;
  logic             err_ovf;
  logic             err_unf;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // Behavioural model state.
  logic [NPROC-1:0] m_stk[$];
  logic             m_ovf = 1'b0;
  logic             m_unf = 1'b0;

  pe_enable_stack #(.NPROC(NPROC), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .op_valid (op_valid),
    .squash   (squash),
    .cond     (cond),
    .err_clr  (err_clr),
    .en       (en),
    .any_en   (any_en),
    .depth    (depth),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: applies the stack rules to the inputs seen at each edge.
  always @(posedge clk) begin
    logic so, su;
    so = 1'b0;
    su = 1'b0;
    if (reset) begin
      m_stk.delete();
      m_stk.push_back('1);
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (m_stk.size() > 0) begin
      if (op_valid && !squash) begin
        case (op)
          3'd1: if (m_stk.size() < DEPTH) m_stk.push_back(m_stk[m_stk.size()-1] & cond);
                else so = 1'b1;
          3'd2: if (m_stk.size() > 1) void'(m_stk.pop_back());
                else su = 1'b1;
          3'd3: m_stk[m_stk.size()-1] = '1;
          3'd4: if (m_stk.size() > 1)
                  m_stk[m_stk.size()-1] = m_stk[m_stk.size()-2] & ~m_stk[m_stk.size()-1];
                else su = 1'b1;
          default: ;
        endcase
      end
      if (so) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
      if (su) m_unf = 1'b1; else if (err_clr) m_unf = 1'b0;
    end
  end

  // Compare process: the outputs are checked against the model on every
  // cycle once the first reset has been applied.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [NPROC-1:0] e;
      e = m_stk[m_stk.size()-1];
      chk("en",      32'(en),      32'(e));
      chk("any_en",  32'(any_en),  32'(|e));
      chk("depth",   32'(depth),   32'(m_stk.size()-1));
      chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
      chk("err_unf", 32'(err_unf), 32'(m_unf));
    end
  end

  // Drive one cycle of inputs, then return just after the following negedge,
  // after the compare process has run.
  task automatic step(input logic [2:0] o, input logic v, input logic s,
                      input logic [NPROC-1:0] c, input logic ec, input logic r);
    op = o; op_valid = v; squash = s; cond = c; err_clr = ec; reset = r;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [NPROC-1:0] e_en,
                     input logic [CW-1:0] e_d, input logic e_o, input logic e_u);
    chk({name, ".en"},    32'(en),      32'(e_en));
    chk({name, ".any"},   32'(any_en),  32'(|e_en));
    chk({name, ".depth"}, 32'(depth),   32'(e_d));
    chk({name, ".ovf"},   32'(err_ovf), 32'(e_o));
    chk({name, ".unf"},   32'(err_unf), 32'(e_u));
  endtask

  initial begin
    @(negedge clk);
    step(3'd0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk_on = 1'b1;
    lit("reset", 4'b1111, 2'd0, 1'b0, 1'b0);

    // Directed sequence with hand-computed expectations.
    step(3'd1, 1'b1, 1'b0, 4'b0101, 1'b0, 1'b0); lit("push0101", 4'b0101, 2'd1, 0, 0);
    step(3'd4, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0); lit("else",     4'b1010, 2'd1, 0, 0);
    step(3'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0); lit("pop",      4'b1111, 2'd0, 0, 0);
    step(3'd1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0); lit("push0000", 4'b0000, 2'd1, 0, 0);
    step(3'd3, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0); lit("allen",    4'b1111, 2'd1, 0, 0);

    step(3'd0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(3'd1, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0);
    lit("push3", 4'b1111, 2'd3, 0, 0);
    step(3'd1, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0); lit("ovf",      4'b1111, 2'd3, 1, 0);
    step(3'd0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0); lit("clr",      4'b1111, 2'd3, 0, 0);
    step(3'd1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0); lit("setwins",  4'b1111, 2'd3, 1, 0);
    step(3'd5, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0); lit("op101",    4'b1111, 2'd3, 1, 0);

    step(3'd0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    step(3'd2, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0); lit("unf",      4'b1111, 2'd0, 0, 1);
    step(3'd4, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0); lit("elseunf",  4'b1111, 2'd0, 0, 1);
    step(3'd1, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0); lit("squash",   4'b1111, 2'd0, 0, 1);
    step(3'd1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0); lit("novalid",  4'b1111, 2'd0, 0, 1);
    step(3'd1, 1'b1, 1'b0, 4'b0011, 1'b0, 1'b0);
    step(3'd1, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0); lit("push2",    4'b0010, 2'd2, 0, 1);
    step(3'd2, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1); lit("rstpop",   4'b1111, 2'd0, 0, 0);

    // Randomized traffic, weighted toward pushes and pops so that both ends
    // of the stack are reached often.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] o;
      int sel;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: o = 3'd1;
        3, 4, 5: o = 3'd2;
        6:       o = 3'd3;
        7:       o = 3'd4;
        8:       o = 3'd0;
        default: o = 3'($urandom_range(5, 7));
      endcase
      step(o, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
           NPROC'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0));
    end

    step(3'd0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
